// File: rtl/wb_commit_unit.sv
// ---------------------------------------------------------------------------
// wb_commit_unit
//
// Write-back sink for the MEM/WB latch. Commits GPR, HI/LO and LLbit writes,
// serves the two ID-stage register read ports with same-cycle bypass of the
// instruction now in WB, and records every committed GPR write in a small
// commit-trace FIFO drained over a valid/ready port. When the FIFO is full and
// cannot drain this cycle, the commit is held and stallreq_wb asks ctrl to
// freeze the pipeline so the same WB instruction retries next cycle.
//
// Parameters
//   TRACE_DEPTH    trace FIFO entries (power of 2, >= 2)
//   TRACE_EN       1: trace FIFO active; 0: never pushes, stallreq_wb stays 0
//
// Ports
//   clk, rst              clock (rising edge), async active-high reset
//   wb_wd/wreg/wdata      GPR write address / enable / data
//   wb_pc                 PC of the WB instruction (trace only)
//   wb_hi/lo/whilo        HI/LO write data and enable
//   wb_LLbit_we/value     LLbit write enable and value
//   flush                 exception flush, clears LLbit
//   re1/raddr1/rdata1     read port 1 (combinational)
//   re2/raddr2/rdata2     read port 2 (combinational)
//   hi_o/lo_o/LLbit_o     HI/LO/LLbit with bypass of the WB write
//   trace_valid/ready     trace FIFO head handshake
//   trace_data            {pc[31:0], wd[4:0], wdata[31:0]} of FIFO head
//   stallreq_wb           hold request to ctrl
// ---------------------------------------------------------------------------
module wb_commit_unit #(
  parameter int TRACE_DEPTH = 4,
  parameter int TRACE_EN    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wb_wd,
  input  logic        wb_wreg,
  input  logic [31:0] wb_wdata,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_hi,
  input  logic [31:0] wb_lo,
  input  logic        wb_whilo,
  input  logic        wb_LLbit_we,
  input  logic        wb_LLbit_value,
  input  logic        flush,
  input  logic        re1,
  input  logic [4:0]  raddr1,
  input  logic        re2,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        LLbit_o,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [68:0] trace_data,
  output logic        stallreq_wb
);

  localparam int PTR_W   = $clog2(TRACE_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 69;

  // Architectural state. Entry 0 of the GPR array is never written, so $0
  // stays zero and reads of it are forced to zero anyway.
  logic [31:0]        gpr_q [32];
  logic [31:0]        hi_q;
  logic [31:0]        lo_q;
  logic               llbit_q;
  logic               llbit_d;

  // Trace FIFO state.
  logic [ENTRY_W-1:0] fifo_q [TRACE_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               gpr_we;
  logic               push_req;
  logic               pop;
  logic               full;
  logic               hold;
  logic               commit;
  logic               push;

  // A commit wants a trace slot only when it really changes a GPR.
  assign gpr_we   = wb_wreg && (wb_wd != 5'd0);
  assign push_req = (TRACE_EN != 0) && gpr_we;
  assign pop      = trace_valid && trace_ready;
  assign full     = (count_q == CNT_W'(TRACE_DEPTH));

  // A simultaneous pop frees the slot, so a full FIFO only blocks when the
  // consumer is not taking the head this cycle.
  assign hold        = push_req && full && !pop;
  assign commit      = !hold;
  assign push        = push_req && commit;
  assign stallreq_wb = hold;

  assign trace_valid = (count_q != '0);
  assign trace_data  = fifo_q[rd_ptr_q];

  // Read ports: $0 and disabled ports read zero; the WB write is forwarded
  // even while held, because the reader is stalled behind the same hold.
  always_comb begin
    rdata1 = 32'd0;
    if (re1 && (raddr1 != 5'd0)) begin
      if (wb_wreg && (raddr1 == wb_wd)) rdata1 = wb_wdata;
      else                               rdata1 = gpr_q[raddr1];
    end
  end

  always_comb begin
    rdata2 = 32'd0;
    if (re2 && (raddr2 != 5'd0)) begin
      if (wb_wreg && (raddr2 == wb_wd)) rdata2 = wb_wdata;
      else                               rdata2 = gpr_q[raddr2];
    end
  end

  // HI/LO and LLbit views include the value about to be committed.
  always_comb begin
    hi_o = wb_whilo ? wb_hi : hi_q;
    lo_o = wb_whilo ? wb_lo : lo_q;
  end

  always_comb begin
    LLbit_o = llbit_q;
    if (flush)            LLbit_o = 1'b0;
    else if (wb_LLbit_we) LLbit_o = wb_LLbit_value;
  end

  // Flush clears LLbit ahead of any LL/SC update in the same cycle.
  always_comb begin
    llbit_d = llbit_q;
    if (commit) begin
      if (flush)            llbit_d = 1'b0;
      else if (wb_LLbit_we) llbit_d = wb_LLbit_value;
    end
  end

  // FIFO pointer/count next state; pointers wrap naturally at PTR_W bits.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Architectural registers: all writes are suppressed while holding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) gpr_q[i] <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      llbit_q <= 1'b0;
    end else begin
      if (commit && gpr_we) gpr_q[wb_wd] <= wb_wdata;
      if (commit && wb_whilo) begin
        hi_q <= wb_hi;
        lo_q <= wb_lo;
      end
      llbit_q <= llbit_d;
    end
  end

  // Trace FIFO storage and pointers; reset drops every queued entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TRACE_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) fifo_q[wr_ptr_q] <= {wb_pc, wb_wd, wb_wdata};
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
